rasterizer: RTL and testbench
=============================

Name: rasterizer

Overview:
- Single-triangle scan rasterizer. On `i_go` it latches three vertices and walks every framebuffer pixel in row-major order.
- It emits one framebuffer write per clock: fill colour if the pixel lies inside the triangle, background colour otherwise.
- It sits between geometry setup and a framebuffer RAM (write port: vertical address, horizontal address, RGB444, write enable).

Parameters:
- VERT_RESOLUTION, 60, framebuffer rows.
- HORIZ_RESOLUTION, 80, framebuffer columns.
- COORD_WIDTH, 8, unsigned vertex coordinate width; vertices may lie off-screen.

Ports:
- i_clk  in  1  clock
- i_srst  in  1  reset; synchronous, active-high
- i_go  in  1  start request, sampled in IDLE/DONE only
- i_triangle_point_0_x  in  COORD_WIDTH  vertex 0 x
- i_triangle_point_0_y  in  COORD_WIDTH  vertex 0 y
- i_triangle_point_1_x  in  COORD_WIDTH  vertex 1 x
- i_triangle_point_1_y  in  COORD_WIDTH  vertex 1 y
- i_triangle_point_2_x  in  COORD_WIDTH  vertex 2 x
- i_triangle_point_2_y  in  COORD_WIDTH  vertex 2 y
- o_vert_write_addr  out  clog2(VERT_RESOLUTION)  pixel row (y)
- o_horiz_write_addr  out  clog2(HORIZ_RESOLUTION)  pixel column (x)
- o_red, o_green, o_blue  out  4 each  pixel colour
- o_write_en  out  1  write strobe
- o_done  out  1  frame complete

Behaviour:
- Reset (i_srst=1 at a clock edge): state=IDLE; all outputs 0. Reset mid-raster aborts immediately; no further writes.
- States and transitions:
  - IDLE --(i_go)--> SETUP.
  - SETUP (1 cycle): latch vertices; compute signed edge deltas and area A = E01(p2).
  - SETUP --> RASTER with x=0, y=0.
  - RASTER: one pixel per cycle; x increments, wraps at HORIZ_RESOLUTION-1 to 0 with y+1.
  - After pixel (H-1, V-1): RASTER --> DONE.
  - DONE --(i_go)--> SETUP.
- i_go is ignored in SETUP/RASTER. Vertex inputs are ignored except in the SETUP latch cycle.
- Output stage: all outputs registered; outputs for pixel (x,y) appear the cycle after it is evaluated.
  - First o_write_en is 3 cycles after the edge sampling i_go.
  - o_write_en is then high for exactly V*H consecutive cycles; addresses are row-major 0..H-1 within each row 0..V-1.
- o_done:
  - rises the cycle after the last write;
  - stays high in DONE;
  - clears in the cycle i_go is accepted.
- Inside test, pixel sample point at integer (x,y):
  - E_ab(p) = (p.x-a.x)*(b.y-a.y) - (p.y-a.y)*(b.x-a.x), for edges 0→1, 1→2, 2→0.
  - Differences are signed COORD_WIDTH+1 bits; products and sums are signed 2*COORD_WIDTH+3 bits, with no overflow possible.
  - Inside iff all three E ≥ 0 or all three E ≤ 0 (either winding; edges and vertices inclusive).
  - If A == 0 (degenerate/collinear), no pixel is inside.
- Colours: inside = R=G=B=4'hF; outside = 4'h0. When o_write_en=0, colour outputs are 0.
- Addresses hold the last value when not writing (don't-care for consumers).

Decomposition:
- Package rasterizer_pkg:
  - state enum {IDLE, SETUP, RASTER, DONE};
  - FILL_COLOR and BG_COLOR constants (12-bit RGB444);
  - coordinate/edge-value width localparams.
- One sub-module `edge_function`: combinational signed evaluation of E_ab(p). Instantiate three times; the inside/degenerate logic stays in the top.

Test Plan:
- Reset 5 cycles then idle 20 cycles → every output 0, o_done=0, no writes.
- i_go one cycle, triangle (10,10),(10,70),(70,30), 80x60 frame:
  - exactly 4800 writes, row-major, first write 3 cycles after i_go, o_done high the cycle after the last write;
  - (30,30) = F/F/F; (10,10) vertex = F/F/F; (10,40) edge = F/F/F;
  - (0,0), (5,30), (60,10), (79,59) = 0/0/0.
- Same triangle with vertices 1 and 2 swapped → identical pixel map.
- Collinear triangle (0,0),(20,20),(40,40) → 4800 writes, all black.
- i_go pulsed mid-raster → ignored; write count still 4800 and ordering unbroken. Then i_go in DONE → o_done clears and a second full frame follows.
- i_srst asserted mid-raster → next cycle o_write_en=0, o_done=0, state IDLE. A subsequent i_go produces a full 4800-write frame.

Source files
------------

// File: rtl/rasterizer_pkg.sv
// rasterizer_pkg: shared state encoding, colours and width helpers for the triangle rasterizer.
package rasterizer_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, RASTER, DONE} state_t;
   localparam logic [11:0] FILL_COLOR = 12'hFFF;
   localparam logic [11:0] BG_COLOR = 12'h000;
   localparam int DEF_COORD_WIDTH = 8;
   // Two (COORD_WIDTH+1)-bit signed products plus one bit of headroom for their difference.
   function automatic int edge_width(input int cw);
      return 2 * cw + 3;
   endfunction
endpackage

// File: rtl/edge_function.sv
// edge_function: signed edge value E_ab(p) = (p.x-a.x)*(b.y-a.y) - (p.y-a.y)*(b.x-a.x).
module edge_function
   import rasterizer_pkg::*;
#(
   parameter int COORD_WIDTH = DEF_COORD_WIDTH
) (
   input  logic [COORD_WIDTH-1:0]         i_a_x,
   input  logic [COORD_WIDTH-1:0]         i_a_y,
   input  logic [COORD_WIDTH-1:0]         i_b_x,
   input  logic [COORD_WIDTH-1:0]         i_b_y,
   input  logic [COORD_WIDTH-1:0]         i_p_x,
   input  logic [COORD_WIDTH-1:0]         i_p_y,
   output logic signed [2*COORD_WIDTH+2:0] o_e
);
   localparam int EW = edge_width(COORD_WIDTH);
   logic signed [COORD_WIDTH:0] w_dpx, w_dpy, w_dbx, w_dby;
   assign w_dpx = $signed({1'b0, i_p_x}) - $signed({1'b0, i_a_x});
   assign w_dpy = $signed({1'b0, i_p_y}) - $signed({1'b0, i_a_y});
   assign w_dbx = $signed({1'b0, i_b_x}) - $signed({1'b0, i_a_x});
   assign w_dby = $signed({1'b0, i_b_y}) - $signed({1'b0, i_a_y});
   assign o_e = EW'(w_dpx) * EW'(w_dby) - EW'(w_dpy) * EW'(w_dbx);
endmodule

// File: rtl/rasterizer.sv
// rasterizer: walks the whole framebuffer row-major after i_go, writing fill colour inside
// the latched triangle and background elsewhere, one registered write per clock.
module rasterizer
   import rasterizer_pkg::*;
#(
   parameter int VERT_RESOLUTION  = 60,
   parameter int HORIZ_RESOLUTION = 80,
   parameter int COORD_WIDTH      = DEF_COORD_WIDTH
) (
   input  logic                                i_clk,
   input  logic                                i_srst,
   input  logic                                i_go,
   input  logic [COORD_WIDTH-1:0]              i_triangle_point_0_x,
   input  logic [COORD_WIDTH-1:0]              i_triangle_point_0_y,
   input  logic [COORD_WIDTH-1:0]              i_triangle_point_1_x,
   input  logic [COORD_WIDTH-1:0]              i_triangle_point_1_y,
   input  logic [COORD_WIDTH-1:0]              i_triangle_point_2_x,
   input  logic [COORD_WIDTH-1:0]              i_triangle_point_2_y,
   output logic [$clog2(VERT_RESOLUTION)-1:0]  o_vert_write_addr,
   output logic [$clog2(HORIZ_RESOLUTION)-1:0] o_horiz_write_addr,
   output logic [3:0]                          o_red,
   output logic [3:0]                          o_green,
   output logic [3:0]                          o_blue,
   output logic                                o_write_en,
   output logic                                o_done
);
   localparam int VW = $clog2(VERT_RESOLUTION);
   localparam int HW = $clog2(HORIZ_RESOLUTION);
   localparam int EW = edge_width(COORD_WIDTH);
   state_t r_state, w_next;
   logic [COORD_WIDTH-1:0] r_vx [3];
   logic [COORD_WIDTH-1:0] r_vy [3];
   logic [HW-1:0] r_x, r_px;
   logic [VW-1:0] r_y, r_py;
   logic r_v1, r_in;
   logic w_latch, w_eval, w_last, w_xwrap, w_inside;
   logic signed [EW-1:0] w_e [3];
   logic signed [EW-1:0] w_area;
   always_ff @(posedge i_clk) begin
      if (i_srst) r_state <= IDLE;
      else r_state <= w_next;
   end
   always_comb begin
      w_next = (r_state == IDLE || r_state == DONE) ? (i_go ? SETUP : r_state) :
               (r_state == SETUP) ? RASTER :
               w_last ? DONE : RASTER;
   end
   always_comb begin
      w_latch = (r_state == SETUP);
      w_eval  = (r_state == RASTER);
   end
   assign w_xwrap = (r_x == HW'(HORIZ_RESOLUTION - 1));
   assign w_last  = w_xwrap && (r_y == VW'(VERT_RESOLUTION - 1));
   for (genvar g = 0; g < 3; g++) begin : g_edge
      edge_function #(.COORD_WIDTH(COORD_WIDTH)) u_edge (
         .i_a_x(r_vx[g]),         .i_a_y(r_vy[g]),
         .i_b_x(r_vx[(g+1)%3]),   .i_b_y(r_vy[(g+1)%3]),
         .i_p_x(COORD_WIDTH'(r_x)), .i_p_y(COORD_WIDTH'(r_y)),
         .o_e(w_e[g])
      );
   end
   edge_function #(.COORD_WIDTH(COORD_WIDTH)) u_area (
      .i_a_x(r_vx[0]), .i_a_y(r_vy[0]),
      .i_b_x(r_vx[1]), .i_b_y(r_vy[1]),
      .i_p_x(r_vx[2]), .i_p_y(r_vy[2]),
      .o_e(w_area)
   );
   // Either winding counts; zero area means collinear vertices and nothing is filled.
   assign w_inside = (w_area != 0) &&
      ((w_e[0] >= 0 && w_e[1] >= 0 && w_e[2] >= 0) ||
       (w_e[0] <= 0 && w_e[1] <= 0 && w_e[2] <= 0));
   always_ff @(posedge i_clk) begin
      if (w_latch) begin
         r_vx <= '{i_triangle_point_0_x, i_triangle_point_1_x, i_triangle_point_2_x};
         r_vy <= '{i_triangle_point_0_y, i_triangle_point_1_y, i_triangle_point_2_y};
      end
   end
   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         r_x                <= '0;
         r_y                <= '0;
         r_px               <= '0;
         r_py               <= '0;
         r_v1               <= 1'b0;
         r_in               <= 1'b0;
         o_write_en         <= 1'b0;
         o_done             <= 1'b0;
         o_horiz_write_addr <= '0;
         o_vert_write_addr  <= '0;
         {o_red, o_green, o_blue} <= '0;
      end else begin
         if (w_latch) begin
            r_x <= '0;
            r_y <= '0;
         end else if (w_eval) begin
            r_x <= w_xwrap ? '0 : r_x + 1'b1;
            r_y <= w_xwrap ? r_y + 1'b1 : r_y;
         end
         r_v1 <= w_eval;
         r_in <= w_inside;
         r_px <= r_x;
         r_py <= r_y;
         o_write_en <= r_v1;
         if (r_v1) begin
            o_horiz_write_addr <= r_px;
            o_vert_write_addr  <= r_py;
         end
         {o_red, o_green, o_blue} <= r_v1 ? (r_in ? FILL_COLOR : BG_COLOR) : 12'h000;
         // Raised once the pipeline has drained its last write; cleared when a new frame is accepted.
         o_done <= (r_state == DONE) && !r_v1 && !i_go;
      end
   end
endmodule

// File: tb/tb_rasterizer.sv
// tb_rasterizer: directed frames checked pixel-by-pixel against an integer edge-function model.
module tb_rasterizer;
   logic       clk = 1'b0;
   logic       srst = 1'b1;
   logic       go = 1'b0;
   logic [7:0] p0x = '0, p0y = '0, p1x = '0, p1y = '0, p2x = '0, p2y = '0;
   logic [5:0] vaddr;
   logic [6:0] haddr;
   logic [3:0] red, green, blue;
   logic       we, done;
   int         total = 0;
   int         fails = 0;
   bit         map [60][80];
   bit         saved [60][80];

   rasterizer dut (
      .i_clk(clk), .i_srst(srst), .i_go(go),
      .i_triangle_point_0_x(p0x), .i_triangle_point_0_y(p0y),
      .i_triangle_point_1_x(p1x), .i_triangle_point_1_y(p1y),
      .i_triangle_point_2_x(p2x), .i_triangle_point_2_y(p2y),
      .o_vert_write_addr(vaddr), .o_horiz_write_addr(haddr),
      .o_red(red), .o_green(green), .o_blue(blue),
      .o_write_en(we), .o_done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int ef(input int ax, ay, bx, by, px, py);
      return (px - ax) * (by - ay) - (py - ay) * (bx - ax);
   endfunction

   function automatic bit model(input int ax, ay, bx, by, cx, cy, px, py);
      int e0, e1, e2;
      if (ef(ax, ay, bx, by, cx, cy) == 0) return 1'b0;
      e0 = ef(ax, ay, bx, by, px, py);
      e1 = ef(bx, by, cx, cy, px, py);
      e2 = ef(cx, cy, ax, ay, px, py);
      return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
   endfunction

   // Runs one frame from i_go; go_at pulses i_go mid-raster, rst_at asserts reset mid-raster.
   task automatic frame(input string tag, input int ax, ay, bx, by, cx, cy,
                        input int go_at, input int rst_at);
      int first = -1, ex = 0, ey = 0, nwr = 0, ordbad = 0, colbad = 0, gaps = 0, lit = 0;
      int mlit = 0;
      bit fin = 1'b0;
      bit m;
      p0x = 8'(ax); p0y = 8'(ay); p1x = 8'(bx); p1y = 8'(by); p2x = 8'(cx); p2y = 8'(cy);
      go = 1'b1;
      for (int c = 1; c <= 4900 && !fin; c++) begin
         @(negedge clk);
         if (c == 1) chk({tag, "_done_clear"}, int'(done), 0);
         if (we) begin
            if (first < 0) first = c;
            if (nwr >= 4800) ordbad++;
            else begin
               if (haddr !== 7'(ex) || vaddr !== 6'(ey)) ordbad++;
               m = model(ax, ay, bx, by, cx, cy, ex, ey);
               mlit += int'(m);
               if ({red, green, blue} !== (m ? 12'hFFF : 12'h000)) colbad++;
               map[ey][ex] = (red == 4'hF);
               lit += int'(red == 4'hF);
               if (ex == 79) begin ex = 0; ey++; end
               else ex++;
            end
            nwr++;
         end else begin
            if ({red, green, blue} !== 12'h000) colbad++;
            if (first >= 0 && nwr < 4800) gaps++;
            if (nwr == 4800) begin
               chk({tag, "_done_after_last"}, int'(done), 1);
               fin = 1'b1;
            end
         end
         go = (c == go_at);
         if (c == 2) begin
            p0x = 8'd3; p0y = 8'd250; p1x = 8'd77; p1y = 8'd1; p2x = 8'd200; p2y = 8'd55;
         end
         if (c == rst_at) begin
            srst = 1'b1;
            @(negedge clk);
            chk({tag, "_rst_we"}, int'(we), 0);
            chk({tag, "_rst_done"}, int'(done), 0);
            srst = 1'b0;
            nwr = 0;
            for (int k = 0; k < 10; k++) begin
               @(negedge clk);
               nwr += int'(we) + int'(done);
            end
            chk({tag, "_rst_quiet"}, nwr, 0);
            return;
         end
      end
      go = 1'b0;
      chk({tag, "_finished"}, int'(fin), 1);
      chk({tag, "_writes"}, nwr, 4800);
      chk({tag, "_first_cycle"}, first, 4);
      chk({tag, "_order_errs"}, ordbad, 0);
      chk({tag, "_colour_errs"}, colbad, 0);
      chk({tag, "_gaps"}, gaps, 0);
      chk({tag, "_lit_vs_model"}, lit, mlit);
   endtask

   initial begin
      int bad;
      srst = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_we", int'(we), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_rgb", int'({red, green, blue}), 0);
      chk("rst_addr", int'({vaddr, haddr}), 0);
      srst = 1'b0;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         bad += int'(we) + int'(done) + int'({red, green, blue} != 0);
      end
      chk("idle_quiet", bad, 0);

      frame("tri", 10, 10, 10, 70, 70, 30, 0, 0);
      chk("px_30_30", int'(map[30][30]), 1);
      chk("px_vertex_10_10", int'(map[10][10]), 1);
      chk("px_edge_10_40", int'(map[40][10]), 1);
      chk("px_0_0", int'(map[0][0]), 0);
      chk("px_5_30", int'(map[30][5]), 0);
      chk("px_60_10", int'(map[10][60]), 0);
      chk("px_79_59", int'(map[59][79]), 0);
      saved = map;

      frame("swap", 10, 10, 70, 30, 10, 70, 0, 0);
      bad = 0;
      for (int y = 0; y < 60; y++)
         for (int x = 0; x < 80; x++)
            bad += int'(map[y][x] != saved[y][x]);
      chk("swap_map_diff", bad, 0);
      chk("swap_px_30_30", int'(map[30][30]), 1);

      frame("collinear", 0, 0, 20, 20, 40, 40, 0, 0);
      bad = 0;
      for (int y = 0; y < 60; y++)
         for (int x = 0; x < 80; x++)
            bad += int'(map[y][x]);
      chk("collinear_lit", bad, 0);

      frame("go_mid", 10, 10, 10, 70, 70, 30, 1000, 0);
      chk("go_mid_done_held", int'(done), 1);
      frame("from_done", 5, 50, 75, 55, 40, 2, 0, 0);

      frame("rst_mid", 10, 10, 10, 70, 70, 30, 0, 2000);
      frame("after_rst", 10, 10, 10, 70, 70, 30, 0, 0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule
